// File: rtl/cart_slot_if.sv
// CPU bus and ioctl loader signals shared between the system top level and the cartridge slot.
interface cart_slot_if #(
   parameter int unsigned ADDR_WIDTH = 14
) ();
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [7:0]            cpu_dout;
   logic                  cpu_rw;
   logic                  clk_e;
   logic                  clk_q;
   logic                  rom_cs;
   logic                  bank_cs;
   logic [7:0]            rom_dout;
   logic                  ioctl_download;
   logic                  ioctl_wr;
   logic [7:0]            ioctl_index;
   logic [23:0]           ioctl_addr;
   logic [7:0]            ioctl_data;

   modport master (
      output cpu_addr, cpu_dout, cpu_rw, clk_e, clk_q, rom_cs, bank_cs,
      output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_data,
      input  rom_dout
   );

   modport slave (
      input  cpu_addr, cpu_dout, cpu_rw, clk_e, clk_q, rom_cs, bank_cs,
      input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_data,
      output rom_dout
   );
endinterface

// File: rtl/cart_slot.sv
// Bank-switched cartridge ROM slot: captures the ioctl image, detects a valid cart,
// serves $C000 window reads, drives the CART FIRQ line and a post-load reset request.
module cart_slot #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned BANK_BITS  = 2,
   parameter int unsigned CART_INDEX = 1,
   parameter int unsigned DETECT_MIN = 256,
   parameter int unsigned RST_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   cart_slot_if.slave           bus,
   input  logic                 eject,
   output logic                 cart_present,
   output logic                 cart_firq,
   output logic                 cart_reset_req,
   output logic [BANK_BITS-1:0] bank
);
   localparam int unsigned PHYS_W = ADDR_WIDTH + BANK_BITS;
   localparam int unsigned DEPTH  = 1 << PHYS_W;
   localparam int unsigned LEN_W  = PHYS_W + 1;
   localparam int unsigned CNT_W  = $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, LOADING, RSTREQ} state_e;

   state_e               state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 present_q, present_d;
   logic [BANK_BITS-1:0] bank_q, bank_d;
   logic                 req_q, req_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [7:0]           rom_dout_q, rom_dout_d;
   logic                 firq_q, firq_d;
   logic                 dl_q, stb_q;

   logic [7:0]           mem [DEPTH];
   logic                 mem_we;
   logic                 stb, dl_start, dl_fall, in_range;
   logic [LEN_W-1:0]     addr_p1;
   logic [PHYS_W-1:0]    phys;
   logic                 unused_bits;

   assign stb      = bus.bank_cs & ~bus.cpu_rw & bus.clk_e;
   assign dl_start = bus.ioctl_download & ~dl_q & (bus.ioctl_index == 8'(CART_INDEX));
   assign dl_fall  = ~bus.ioctl_download & dl_q;
   assign in_range = (bus.ioctl_addr >> PHYS_W) == 24'd0;
   assign addr_p1  = LEN_W'(bus.ioctl_addr[PHYS_W-1:0]) + LEN_W'(1);
   assign phys     = {bank_q, bus.cpu_addr};
   assign unused_bits = ^bus.cpu_dout;

   // Next-state: priority is eject, then download start, then normal sequencing.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      present_d = present_q;
      bank_d    = bank_q;
      req_d     = req_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;

      case (state_q)
         LOADING: begin
            if (bus.ioctl_wr && in_range) begin
               mem_we = 1'b1;
               if (addr_p1 > len_q) len_d = addr_p1;
            end
            if (dl_fall) begin
               if (len_d >= LEN_W'(DETECT_MIN)) begin
                  present_d = 1'b1;
                  req_d     = 1'b1;
                  cnt_d     = CNT_W'(RST_CYCLES - 1);
                  state_d   = RSTREQ;
               end else begin
                  state_d   = IDLE;
               end
            end
         end
         RSTREQ: begin
            if (cnt_q == '0) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (stb && !stb_q && present_q) bank_d = bus.cpu_dout[BANK_BITS-1:0];

      if (dl_start) begin
         state_d   = LOADING;
         len_d     = '0;
         present_d = 1'b0;
         bank_d    = '0;
         req_d     = 1'b0;
         mem_we    = 1'b0;
      end

      if (eject) begin
         state_d   = IDLE;
         present_d = 1'b0;
         bank_d    = '0;
         req_d     = 1'b0;
         mem_we    = 1'b0;
      end
   end

   // Read path uses the bank as registered at the previous edge.
   always_comb begin
      rom_dout_d = 8'hFF;
      if (bus.rom_cs && present_q && (LEN_W'(phys) < len_q) && (state_q != LOADING))
         rom_dout_d = mem[phys];
      firq_d = present_q & bus.clk_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         present_q  <= 1'b0;
         bank_q     <= '0;
         req_q      <= 1'b0;
         cnt_q      <= '0;
         rom_dout_q <= 8'hFF;
         firq_q     <= 1'b0;
         dl_q       <= bus.ioctl_download;
         stb_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         present_q  <= present_d;
         bank_q     <= bank_d;
         req_q      <= req_d;
         cnt_q      <= cnt_d;
         rom_dout_q <= rom_dout_d;
         firq_q     <= firq_d;
         dl_q       <= bus.ioctl_download;
         stb_q      <= stb;
      end
   end

   // Image storage survives reset and eject.
   always_ff @(posedge clk) begin
      if (mem_we) mem[bus.ioctl_addr[PHYS_W-1:0]] <= bus.ioctl_data;
   end

   assign bus.rom_dout    = rom_dout_q;
   assign cart_present    = present_q;
   assign cart_firq       = firq_q;
   assign cart_reset_req  = req_q;
   assign bank            = bank_q;
endmodule

// File: tb/tb_cart_slot.sv
// Directed self-checking bench for cart_slot.
module tb_cart_slot;
   logic       clk = 1'b0;
   logic       reset;
   logic       eject;
   logic       cart_present;
   logic       cart_firq;
   logic       cart_reset_req;
   logic [1:0] bank;
   int         n_checks = 0;
   int         n_errors = 0;
   int         n;

   cart_slot_if #(.ADDR_WIDTH(14)) bus ();

   cart_slot #(
      .ADDR_WIDTH(14), .BANK_BITS(2), .CART_INDEX(1), .DETECT_MIN(256), .RST_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .eject(eject),
      .cart_present(cart_present), .cart_firq(cart_firq),
      .cart_reset_req(cart_reset_req), .bank(bank)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int a);
      return 8'(a) ^ 8'(a >> 8);
   endfunction

   task automatic dl_start(input logic [7:0] idx);
      bus.ioctl_index    = idx;
      bus.ioctl_download = 1'b1;
      tick();
   endtask

   task automatic dl_write(input int a, input logic [7:0] d);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 24'(a);
      bus.ioctl_data = d;
      tick();
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic dl_end();
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_download = 1'b0;
      tick();
   endtask

   task automatic rd(input int a);
      bus.rom_cs   = 1'b1;
      bus.cpu_rw   = 1'b1;
      bus.cpu_addr = 14'(a);
      tick();
   endtask

   task automatic bank_wr(input logic [7:0] d);
      bus.bank_cs  = 1'b1;
      bus.cpu_rw   = 1'b0;
      bus.clk_e    = 1'b1;
      bus.cpu_dout = d;
      tick();
      bus.bank_cs  = 1'b0;
      bus.cpu_rw   = 1'b1;
      bus.clk_e    = 1'b0;
   endtask

   task automatic count_req(output int cnt);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (cart_reset_req) cnt++;
         tick();
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; eject = 1'b0;
      bus.cpu_addr = '0; bus.cpu_dout = '0; bus.cpu_rw = 1'b1; bus.clk_e = 1'b0; bus.clk_q = 1'b0;
      bus.rom_cs = 1'b0; bus.bank_cs = 1'b0; bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0;
      bus.ioctl_index = '0; bus.ioctl_addr = '0; bus.ioctl_data = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_dout", 32'(bus.rom_dout), 32'hFF);
      check("rst_present", 32'(cart_present), 0);
      check("rst_firq", 32'(cart_firq), 0);
      check("rst_req", 32'(cart_reset_req), 0);
      check("rst_bank", 32'(bank), 0);

      // Short image plus an out-of-range byte: must not count as present.
      dl_start(8'd1);
      for (int i = 0; i < 128; i++) dl_write(i, pat(i));
      dl_write(24'h10000, 8'h55);
      dl_end();
      check("short_present", 32'(cart_present), 0);
      count_req(n);
      check("short_req", 32'(n), 0);
      bank_wr(8'd3);
      check("short_bank", 32'(bank), 0);
      bus.clk_q = 1'b1;
      rd(5);
      check("short_read", 32'(bus.rom_dout), 32'hFF);
      check("short_firq", 32'(cart_firq), 0);
      bus.clk_q = 1'b0;
      bus.rom_cs = 1'b0;

      // 8 KB image.
      dl_start(8'd1);
      for (int i = 0; i < 8192; i++) dl_write(i, pat(i));
      dl_end();
      check("8k_present", 32'(cart_present), 1);
      check("8k_req_rise", 32'(cart_reset_req), 1);
      count_req(n);
      check("8k_req_len", 32'(n), 16);
      rd(16'h0010);
      check("8k_rd_c010", 32'(bus.rom_dout), 32'h10);
      rd(16'h1FFF);
      check("8k_rd_last", 32'(bus.rom_dout), 32'hE0);
      rd(16'h2000);
      check("8k_rd_past", 32'(bus.rom_dout), 32'hFF);
      bus.rom_cs = 1'b0;
      tick();
      check("8k_no_cs", 32'(bus.rom_dout), 32'hFF);

      // 9000-byte image: length boundary.
      dl_start(8'd1);
      for (int i = 0; i < 9000; i++) dl_write(i, pat(i));
      dl_end();
      check("9k_present", 32'(cart_present), 1);
      repeat (20) tick();
      rd(8999);
      check("9k_rd_8999", 32'(bus.rom_dout), 32'h04);
      rd(9000);
      check("9k_rd_9000", 32'(bus.rom_dout), 32'hFF);

      // Sparse writes making a 64 KB image; bank switching.
      dl_start(8'd1);
      dl_write(16'hFFFF, 8'hA5);
      dl_write(16'h8000, 8'h80);
      dl_write(0, 8'h3C);
      dl_end();
      check("64k_present", 32'(cart_present), 1);
      repeat (20) tick();
      rd(0);
      check("64k_rd_b0", 32'(bus.rom_dout), 32'h3C);
      bank_wr(8'd2);
      check("64k_same_clk_old_bank", 32'(bus.rom_dout), 32'h3C);
      check("64k_bank2", 32'(bank), 2);
      tick();
      check("64k_rd_b2", 32'(bus.rom_dout), 32'h80);
      bus.bank_cs = 1'b1; bus.cpu_rw = 1'b0; bus.clk_e = 1'b1; bus.cpu_dout = 8'd3;
      tick();
      bus.cpu_dout = 8'd1;
      tick();
      check("64k_bank_once", 32'(bank), 3);
      bus.clk_e = 1'b0; bus.cpu_dout = 8'd0;
      tick();
      check("64k_bank_needs_e", 32'(bank), 3);
      bus.bank_cs = 1'b0; bus.cpu_rw = 1'b1;
      rd(16'h3FFF);
      check("64k_rd_b3_top", 32'(bus.rom_dout), 32'hA5);
      bus.rom_cs = 1'b0;

      // Reset mid-download with the download line still high.
      dl_start(8'd1);
      for (int i = 0; i < 100; i++) dl_write(i, 8'h5A);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("rstmid_present", 32'(cart_present), 0);
      for (int i = 256; i < 300; i++) dl_write(i, 8'h5A);
      dl_end();
      check("rstmid_after_present", 32'(cart_present), 0);
      check("rstmid_after_req", 32'(cart_reset_req), 0);
      dl_start(8'd1);
      for (int i = 0; i < 256; i++) dl_write(i, pat(i));
      dl_write(299, 8'h77);
      dl_end();
      check("fresh_present", 32'(cart_present), 1);
      repeat (20) tick();
      rd(16'h0010);
      check("fresh_rd_10", 32'(bus.rom_dout), 32'h10);
      rd(260);
      check("fresh_rd_stray", 32'(bus.rom_dout), 32'h05);
      rd(299);
      check("fresh_rd_299", 32'(bus.rom_dout), 32'h77);
      rd(300);
      check("fresh_rd_300", 32'(bus.rom_dout), 32'hFF);
      bus.rom_cs = 1'b0;

      // CART line follows Q one clock later.
      for (int k = 0; k < 6; k++) begin
         bus.clk_q = (k % 2 == 0);
         tick();
         check("firq_follow", 32'(cart_firq), 32'(k % 2 == 0));
      end

      // Download for another slot is ignored.
      dl_start(8'd2);
      dl_write(16'h0010, 8'h99);
      dl_end();
      check("idx2_present", 32'(cart_present), 1);
      rd(16'h0010);
      check("idx2_rd", 32'(bus.rom_dout), 32'h10);

      // Eject.
      bank_wr(8'd2);
      check("ej_bank_pre", 32'(bank), 2);
      eject = 1'b1;
      tick();
      eject = 1'b0;
      check("ej_present", 32'(cart_present), 0);
      check("ej_bank", 32'(bank), 0);
      bus.clk_q = 1'b1;
      tick();
      check("ej_firq", 32'(cart_firq), 0);
      rd(16'h0010);
      check("ej_rd", 32'(bus.rom_dout), 32'hFF);
      bus.rom_cs = 1'b0;
      bus.clk_q  = 1'b0;

      // Exactly DETECT_MIN bytes, then restart during the reset pulse.
      dl_start(8'd1);
      for (int i = 0; i < 256; i++) dl_write(i, pat(i));
      dl_end();
      check("min_present", 32'(cart_present), 1);
      repeat (3) tick();
      check("abort_req_pre", 32'(cart_reset_req), 1);
      dl_start(8'd1);
      check("abort_req", 32'(cart_reset_req), 0);
      check("abort_present", 32'(cart_present), 0);
      dl_end();
      check("abort_end_present", 32'(cart_present), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/cart_slot.md
# cart_slot

Parametrised, bank-switched cartridge ROM slot for the CoCo-class top level. It captures a cartridge image from the ioctl download stream, decides whether a cartridge is present, and serves CPU reads in the $C000 window through a selectable bank. It also drives the CART line (cartridge-present FIRQ source, gated by Q) and requests a machine reset after a successful load. It replaces the ad-hoc cart RAM, cart_loaded flag and CB1 gating in the system top level.

## Interface
Parameters:
- ADDR_WIDTH, 14, CPU window address bits (16 KB window).
- BANK_BITS, 2, bank select bits; storage depth is 2^(ADDR_WIDTH+BANK_BITS) bytes.
- CART_INDEX, 1, ioctl_index value that selects this slot.
- DETECT_MIN, 256, minimum loaded length in bytes for a cartridge to count as present.
- RST_CYCLES, 16, length of cart_reset_req in clk cycles.

Ports:
- clk  in  1  system clock (57.272 MHz).
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_WIDTH  CPU address, low bits.
- cpu_dout  in  8  CPU write data.
- cpu_rw  in  1  1 = read.
- clk_e, clk_q  in  1  SAM E and Q clocks.
- rom_cs  in  1  $C000 window select.
- bank_cs  in  1  bank register select ($FF40 decode, external).
- rom_dout  out  8  read data.
- ioctl_download, ioctl_wr  in  1  loader strobes.
- ioctl_index  in  8  loader target.
- ioctl_addr  in  24  loader byte address.
- ioctl_data  in  8  loader byte.
- eject  in  1  level; forces the slot empty.
- cart_present  out  1  a cartridge is loaded and valid.
- cart_firq  out  1  CART line (active high, to PIA1 CB1).
- cart_reset_req  out  1  reset request pulse.
- bank  out  BANK_BITS  current bank, for debug.

## Operation
- The FSM has three states: IDLE, LOADING and RSTREQ.
- Download start:
  - A rising edge of ioctl_download with ioctl_index == CART_INDEX, from any state, enters LOADING.
  - On entry it clears length, cart_present, bank and cart_reset_req.
- LOADING writes:
  - Each ioctl_wr writes ioctl_data to storage[ioctl_addr].
  - length <= max(length, ioctl_addr+1).
  - Addresses >= 2^(ADDR_WIDTH+BANK_BITS) are dropped and do not update length.
- Download end: the falling edge of ioctl_download in LOADING applies the detection rule.
  - If length >= DETECT_MIN: cart_present <= 1 and the FSM enters RSTREQ.
  - Otherwise cart_present stays 0 and the FSM returns to IDLE.
- RSTREQ: cart_reset_req is high for exactly RST_CYCLES clocks, then the FSM returns to IDLE.
- Downloads with another index, and ioctl_wr outside LOADING, are ignored.
- Bank register:
  - A write (bank_cs & ~cpu_rw & clk_e) loads bank <= cpu_dout[BANK_BITS-1:0] once, on the first clk of the strobe (edge detected).
  - The register is ignored while cart_present = 0.
- CPU read: the physical address is {bank, cpu_addr}.
  - rom_dout = storage byte if rom_cs & cart_present & physical address < length & state != LOADING.
  - Otherwise rom_dout = 8'hFF.
- cart_firq = cart_present & clk_q, registered.
- eject = 1 clears cart_present and bank and forces IDLE. This aborts LOADING/RSTREQ and drops cart_reset_req.
- Storage contents are never cleared by reset or eject.
- Reset values: state IDLE, cart_present 0, length 0, bank 0, rom_dout 8'hFF, cart_firq 0, cart_reset_req 0.

## Timing
- Read latency is 1 clk: rom_dout reflects rom_cs, the address and bank sampled at the previous clk edge.
- Bank write and read in the same clk: the read uses the old bank. The new bank is visible from the next edge.
- Download writes take effect in 1 clk. A read of the same address in the next cycle returns the new byte, once LOADING has exited.
- Detection: cart_present rises 1 clk after the download falling edge. cart_reset_req rises in that same cycle and is high for RST_CYCLES clks.
- cart_firq follows clk_q with 1 clk delay.
- Reset mid-download:
  - The FSM goes to IDLE and later ioctl_wr is ignored.
  - The next download rising edge restarts loading normally.
  - If ioctl_download is still high when reset releases, no edge is inferred.
- A new download start during RSTREQ aborts the pulse on the next clk.

## Test plan
- Load 8192 bytes (data = addr[7:0]) at index 1 -> cart_present=1 one clk after download falls; cart_reset_req high for 16 clks; read $C010 returns 8'h10 after 1 clk.
- Load 128 bytes -> cart_present stays 0, no reset_req; every read returns 8'hFF; cart_firq stays 0.
- Load 64 KB; write 2 to bank_cs, then read cpu_addr 0 -> returns byte 0x8000; a bank write and read in the same clk return the bank-0 byte.
- Load 9000 bytes, bank 0 -> reads at 8999 return data; reads at 9000 and above return 8'hFF.
- Assert reset at byte 100 of a download, deassert it, then continue ioctl_wr -> no storage writes, cart_present 0; a fresh download completes normally.
- Cart loaded, clk_q toggling -> cart_firq mirrors clk_q delayed 1 clk; pulse eject -> cart_firq 0, reads return FF, bank 0.
